// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds renamed ALU/branch/jump ops until both operands are valid,
// snoops result broadcasts and issues the lowest ready entry. Define RS_LSB_SNOOP_EN for LSB snoop.
module alu_reservation_station #(
  parameter int unsigned RS_SIZE = 8,
  parameter int unsigned ROB_W   = 4,
  parameter int unsigned OP_W    = 6,
  parameter int unsigned XLEN    = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rdy_i,
  input  logic             clear_i,
  input  logic             disp_valid_i,
  input  logic [OP_W-1:0]  disp_op_i,
  input  logic [ROB_W-1:0] disp_rd_rename_i,
  input  logic [XLEN-1:0]  disp_pc_i,
  input  logic [XLEN-1:0]  disp_imm_i,
  input  logic [XLEN-1:0]  disp_vj_i,
  input  logic [XLEN-1:0]  disp_vk_i,
  input  logic [ROB_W-1:0] disp_qj_i,
  input  logic [ROB_W-1:0] disp_qk_i,
  input  logic             disp_qj_busy_i,
  input  logic             disp_qk_busy_i,
  output logic             rs_full_o,
  input  logic             alu_bc_valid_i,
  input  logic [ROB_W-1:0] alu_bc_rename_i,
  input  logic [XLEN-1:0]  alu_bc_result_i,
`ifdef RS_LSB_SNOOP_EN
  input  logic             lsb_bc_valid_i,
  input  logic [ROB_W-1:0] lsb_bc_rename_i,
  input  logic [XLEN-1:0]  lsb_bc_result_i,
`endif
  output logic             alu_enable_o,
  output logic [OP_W-1:0]  alu_op_o,
  output logic [ROB_W-1:0] alu_rd_rename_o,
  output logic [XLEN-1:0]  alu_pc_o,
  output logic [XLEN-1:0]  alu_imm_o,
  output logic [XLEN-1:0]  alu_rs1_value_o,
  output logic [XLEN-1:0]  alu_rs2_value_o
);

  localparam int unsigned IdxW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef struct packed {
    logic             busy;
    logic [OP_W-1:0]  op;
    logic [ROB_W-1:0] rd;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  vj;
    logic [XLEN-1:0]  vk;
    logic [ROB_W-1:0] qj;
    logic [ROB_W-1:0] qk;
    logic             qj_busy;
    logic             qk_busy;
  } entry_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [ROB_W-1:0] rd;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  v1;
    logic [XLEN-1:0]  v2;
  } issue_t;

  entry_t             entry_q [RS_SIZE];
  entry_t             entry_d [RS_SIZE];
  issue_t             out_q;
  logic               en_q;
  logic [RS_SIZE-1:0] busy_vec;
  logic [RS_SIZE-1:0] ready_vec;
  logic [IdxW-1:0]    free_idx;
  logic [IdxW-1:0]    issue_idx;
  logic               any_ready;
  logic [XLEN:0]      wake_j;
  logic [XLEN:0]      wake_k;

  logic               lsb_valid;
  logic [ROB_W-1:0]   lsb_rename;
  logic [XLEN-1:0]    lsb_result;
`ifdef RS_LSB_SNOOP_EN
  assign lsb_valid  = lsb_bc_valid_i;
  assign lsb_rename = lsb_bc_rename_i;
  assign lsb_result = lsb_bc_result_i;
`else
  assign lsb_valid  = 1'b0;
  assign lsb_rename = '0;
  assign lsb_result = '0;
`endif

  // Returns {still_pending, value}; the ALU broadcast wins when both hit the same operand.
  function automatic logic [XLEN:0] wake(input logic pending, input logic [ROB_W-1:0] tag,
                                         input logic [XLEN-1:0] val);
    logic [XLEN:0] r;
    r = {pending, val};
    if (pending && alu_bc_valid_i && (tag == alu_bc_rename_i)) begin
      r = {1'b0, alu_bc_result_i};
    end else if (pending && lsb_valid && (tag == lsb_rename)) begin
      r = {1'b0, lsb_result};
    end
    return r;
  endfunction

  // Descending scan so the lowest matching index is the last one written.
  always_comb begin
    busy_vec  = '0;
    ready_vec = '0;
    free_idx  = '0;
    issue_idx = '0;
    for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
      busy_vec[i]  = entry_q[i].busy;
      ready_vec[i] = entry_q[i].busy && !entry_q[i].qj_busy && !entry_q[i].qk_busy;
      if (!busy_vec[i]) free_idx = IdxW'(i);
      if (ready_vec[i]) issue_idx = IdxW'(i);
    end
  end

  assign rs_full_o = &busy_vec;
  assign any_ready = |ready_vec;

  always_comb begin
    entry_d = entry_q;
    wake_j  = '0;
    wake_k  = '0;
    if (rdy_i) begin
      if (clear_i) begin
        for (int i = 0; i < int'(RS_SIZE); i++) entry_d[i].busy = 1'b0;
      end else begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
          if (entry_q[i].busy) begin
            wake_j = wake(entry_q[i].qj_busy, entry_q[i].qj, entry_q[i].vj);
            wake_k = wake(entry_q[i].qk_busy, entry_q[i].qk, entry_q[i].vk);
            entry_d[i].qj_busy = wake_j[XLEN];
            entry_d[i].vj      = wake_j[XLEN-1:0];
            entry_d[i].qk_busy = wake_k[XLEN];
            entry_d[i].vk      = wake_k[XLEN-1:0];
          end
        end
        if (any_ready) entry_d[issue_idx].busy = 1'b0;
        // Fullness uses the pre-issue state, so the free slot never aliases the issuing one.
        if (disp_valid_i && !rs_full_o) begin
          wake_j = wake(disp_qj_busy_i, disp_qj_i, disp_vj_i);
          wake_k = wake(disp_qk_busy_i, disp_qk_i, disp_vk_i);
          entry_d[free_idx] = '{busy: 1'b1, op: disp_op_i, rd: disp_rd_rename_i,
                                pc: disp_pc_i, imm: disp_imm_i,
                                vj: wake_j[XLEN-1:0], vk: wake_k[XLEN-1:0],
                                qj: disp_qj_i, qk: disp_qk_i,
                                qj_busy: wake_j[XLEN], qk_busy: wake_k[XLEN]};
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(RS_SIZE); i++) entry_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(RS_SIZE); i++) entry_q[i] <= entry_d[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q  <= 1'b0;
      out_q <= '0;
    end else if (rdy_i && !clear_i && any_ready) begin
      en_q  <= 1'b1;
      out_q <= '{op: entry_q[issue_idx].op, rd: entry_q[issue_idx].rd,
                 pc: entry_q[issue_idx].pc, imm: entry_q[issue_idx].imm,
                 v1: entry_q[issue_idx].vj, v2: entry_q[issue_idx].vk};
    end else begin
      en_q <= 1'b0;
    end
  end

  assign alu_enable_o    = en_q;
  assign alu_op_o        = out_q.op;
  assign alu_rd_rename_o = out_q.rd;
  assign alu_pc_o        = out_q.pc;
  assign alu_imm_o       = out_q.imm;
  assign alu_rs1_value_o = out_q.v1;
  assign alu_rs2_value_o = out_q.v2;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Scoreboard bench for alu_reservation_station: directed scenarios plus random traffic checked
// against a slot-array reference model; a monitor pops expected issues on every clock.
`timescale 1ns/1ps
module tb_alu_reservation_station;
  localparam int RS_SIZE = 8;
  localparam int ROB_W   = 4;
  localparam int OP_W    = 6;
  localparam int XLEN    = 32;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b1;
  logic             rdy_i = 1'b1, clear_i = 1'b0, disp_valid_i = 1'b0;
  logic [OP_W-1:0]  disp_op_i = '0;
  logic [ROB_W-1:0] disp_rd_rename_i = '0, disp_qj_i = '0, disp_qk_i = '0;
  logic [XLEN-1:0]  disp_pc_i = '0, disp_imm_i = '0, disp_vj_i = '0, disp_vk_i = '0;
  logic             disp_qj_busy_i = 1'b0, disp_qk_busy_i = 1'b0;
  logic             rs_full_o;
  logic             alu_bc_valid_i = 1'b0;
  logic [ROB_W-1:0] alu_bc_rename_i = '0;
  logic [XLEN-1:0]  alu_bc_result_i = '0;
  logic             alu_enable_o;
  logic [OP_W-1:0]  alu_op_o;
  logic [ROB_W-1:0] alu_rd_rename_o;
  logic [XLEN-1:0]  alu_pc_o, alu_imm_o, alu_rs1_value_o, alu_rs2_value_o;
`ifdef RS_LSB_SNOOP_EN
  logic             lsb_bc_valid_i = 1'b0;
  logic [ROB_W-1:0] lsb_bc_rename_i = '0;
  logic [XLEN-1:0]  lsb_bc_result_i = '0;
`endif

  alu_reservation_station #(
    .RS_SIZE(RS_SIZE), .ROB_W(ROB_W), .OP_W(OP_W), .XLEN(XLEN)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rdy_i(rdy_i), .clear_i(clear_i),
    .disp_valid_i(disp_valid_i), .disp_op_i(disp_op_i), .disp_rd_rename_i(disp_rd_rename_i),
    .disp_pc_i(disp_pc_i), .disp_imm_i(disp_imm_i), .disp_vj_i(disp_vj_i), .disp_vk_i(disp_vk_i),
    .disp_qj_i(disp_qj_i), .disp_qk_i(disp_qk_i),
    .disp_qj_busy_i(disp_qj_busy_i), .disp_qk_busy_i(disp_qk_busy_i),
    .rs_full_o(rs_full_o),
    .alu_bc_valid_i(alu_bc_valid_i), .alu_bc_rename_i(alu_bc_rename_i),
    .alu_bc_result_i(alu_bc_result_i),
`ifdef RS_LSB_SNOOP_EN
    .lsb_bc_valid_i(lsb_bc_valid_i), .lsb_bc_rename_i(lsb_bc_rename_i),
    .lsb_bc_result_i(lsb_bc_result_i),
`endif
    .alu_enable_o(alu_enable_o), .alu_op_o(alu_op_o), .alu_rd_rename_o(alu_rd_rename_o),
    .alu_pc_o(alu_pc_o), .alu_imm_o(alu_imm_o),
    .alu_rs1_value_o(alu_rs1_value_o), .alu_rs2_value_o(alu_rs2_value_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [ROB_W-1:0] rd;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  v1;
    logic [XLEN-1:0]  v2;
  } rec_t;

  // Reference model: one record per slot, "waiting" flags per operand.
  bit               m_busy [RS_SIZE];
  rec_t             m_ent  [RS_SIZE];
  bit               m_jw   [RS_SIZE];
  bit               m_kw   [RS_SIZE];
  logic [ROB_W-1:0] m_qj   [RS_SIZE];
  logic [ROB_W-1:0] m_qk   [RS_SIZE];

  rec_t exp_q[$];
  rec_t last_exp = '0;
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int cnt = 0;
    int rdy_idx = -1;
    int free_idx = -1;
    bit full;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (m_busy[i]) cnt++;
      else if (free_idx < 0) free_idx = i;
      if (m_busy[i] && !m_jw[i] && !m_kw[i] && rdy_idx < 0) rdy_idx = i;
    end
    full = (cnt == RS_SIZE);
    chk("rs_full", 160'(rs_full_o), 160'(full));
    if (!rdy_i) return;
    if (clear_i) begin
      for (int i = 0; i < RS_SIZE; i++) m_busy[i] = 0;
      return;
    end
    if (rdy_idx >= 0) begin
      exp_q.push_back(m_ent[rdy_idx]);
      m_busy[rdy_idx] = 0;
    end
    if (alu_bc_valid_i) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (m_busy[i] && m_jw[i] && m_qj[i] == alu_bc_rename_i) begin
          m_jw[i] = 0; m_ent[i].v1 = alu_bc_result_i;
        end
        if (m_busy[i] && m_kw[i] && m_qk[i] == alu_bc_rename_i) begin
          m_kw[i] = 0; m_ent[i].v2 = alu_bc_result_i;
        end
      end
    end
    if (disp_valid_i && !full) begin
      m_busy[free_idx] = 1;
      m_ent[free_idx] = '{op: disp_op_i, rd: disp_rd_rename_i, pc: disp_pc_i, imm: disp_imm_i,
                          v1: disp_vj_i, v2: disp_vk_i};
      m_qj[free_idx] = disp_qj_i;
      m_qk[free_idx] = disp_qk_i;
      m_jw[free_idx] = disp_qj_busy_i;
      m_kw[free_idx] = disp_qk_busy_i;
      if (disp_qj_busy_i && alu_bc_valid_i && disp_qj_i == alu_bc_rename_i) begin
        m_jw[free_idx] = 0; m_ent[free_idx].v1 = alu_bc_result_i;
      end
      if (disp_qk_busy_i && alu_bc_valid_i && disp_qk_i == alu_bc_rename_i) begin
        m_kw[free_idx] = 0; m_ent[free_idx].v2 = alu_bc_result_i;
      end
    end
  endtask

  // Inputs are set at a falling edge; the model consumes them, then one cycle passes.
  task automatic tick();
    model_step();
    @(negedge clk_i);
  endtask

  task automatic idle();
    rdy_i = 1'b1; clear_i = 1'b0; disp_valid_i = 1'b0; alu_bc_valid_i = 1'b0;
  endtask

  task automatic set_disp(input logic [OP_W-1:0] op, input logic [ROB_W-1:0] rd,
                          input logic [XLEN-1:0] vj, input logic [XLEN-1:0] vk,
                          input logic [XLEN-1:0] imm, input logic [ROB_W-1:0] qj,
                          input logic qjb, input logic [ROB_W-1:0] qk, input logic qkb);
    disp_valid_i = 1'b1; disp_op_i = op; disp_rd_rename_i = rd; disp_vj_i = vj;
    disp_vk_i = vk; disp_imm_i = imm; disp_qj_i = qj; disp_qj_busy_i = qjb;
    disp_qk_i = qk; disp_qk_busy_i = qkb; disp_pc_i = $urandom;
  endtask

  task automatic set_bc(input logic [ROB_W-1:0] tag, input logic [XLEN-1:0] res);
    alu_bc_valid_i = 1'b1; alu_bc_rename_i = tag; alu_bc_result_i = res;
  endtask

  task automatic reset_now();
    rst_ni = 1'b0;
    #1;
    chk("reset_rs_full", 160'(rs_full_o), 160'(0));
    chk("reset_alu_enable", 160'(alu_enable_o), 160'(0));
    for (int i = 0; i < RS_SIZE; i++) m_busy[i] = 0;
    exp_q.delete();
    last_exp = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin : monitor
    rec_t act;
    rec_t e;
    forever begin
      @(posedge clk_i);
      #1;
      act = {alu_op_o, alu_rd_rename_o, alu_pc_o, alu_imm_o, alu_rs1_value_o, alu_rs2_value_o};
      if (alu_enable_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", 160'(act), 160'(0) - 160'(1));
        end else begin
          e = exp_q.pop_front();
          chk("issue_fields", 160'(act), 160'(e));
          last_exp = e;
        end
      end else begin
        chk("alu_enable_low", 160'(alu_enable_o), 160'(exp_q.size() != 0));
        exp_q.delete();
        chk("outputs_hold", 160'(act), 160'(last_exp));
      end
    end
  end

  initial begin : stimulus
    #1 rst_ni = 1'b0;
    #1;
    chk("por_rs_full", 160'(rs_full_o), 160'(0));
    chk("por_alu_enable", 160'(alu_enable_o), 160'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle(); tick();

    // Ready dispatch: ADDI rd=3, vj=5, imm=7.
    set_disp(6'h13, 4'd3, 32'd5, 32'd0, 32'd7, 4'd0, 1'b0, 4'd0, 1'b0); tick();
    idle(); repeat (3) tick();

    // Wakeup by a later broadcast, then by a broadcast in the dispatch cycle.
    set_disp(6'h33, 4'd1, 32'd0, 32'd2, 32'd0, 4'd9, 1'b1, 4'd0, 1'b0); tick();
    idle(); repeat (2) tick();
    set_bc(4'd9, 32'd40); tick();
    idle(); repeat (2) tick();
    set_disp(6'h33, 4'd2, 32'd0, 32'd2, 32'd0, 4'd9, 1'b1, 4'd0, 1'b0);
    set_bc(4'd9, 32'd40); tick();
    idle(); repeat (2) tick();

    // Fill all slots with pending ops, overflow once, wake slot 4.
    for (int i = 0; i < RS_SIZE; i++) begin
      set_disp(OP_W'(i), ROB_W'(i), 32'd0, 32'(i), 32'(i), ROB_W'(i), 1'b1, 4'd0, 1'b0); tick();
    end
    set_disp(6'h3f, 4'd15, 32'd1, 32'd1, 32'd1, 4'd0, 1'b0, 4'd0, 1'b0); tick();
    idle(); tick();
    set_bc(4'd4, 32'd100); tick();
    idle(); repeat (3) tick();

    // Flush with a same-cycle dispatch, then broadcasts must not revive anything.
    set_disp(6'h01, 4'd5, 32'd1, 32'd1, 32'd1, 4'd0, 1'b0, 4'd0, 1'b0);
    clear_i = 1'b1; tick();
    idle(); tick();
    for (int t = 0; t < RS_SIZE; t++) begin
      set_bc(ROB_W'(t), 32'hdead0000 | 32'(t)); tick();
    end
    idle(); tick();

    // Slots 2 and 5 wake together: 2 issues first.
    for (int i = 0; i < RS_SIZE; i++) begin
      set_disp(OP_W'(i + 8), ROB_W'(i), 32'(i), 32'd0, 32'd0,
               (i == 2 || i == 5) ? 4'd12 : ROB_W'(i), 1'b1, 4'd0, 1'b0); tick();
    end
    set_bc(4'd12, 32'd77); tick();
    idle(); repeat (3) tick();
    clear_i = 1'b1; tick();
    idle(); tick();

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 3; i++) begin
      set_disp(6'h22, ROB_W'(i), 32'd0, 32'd0, 32'd0, 4'd13, 1'b1, 4'd0, 1'b0); tick();
    end
    idle();
    #2;
    reset_now();
    set_bc(4'd13, 32'd55); tick();
    idle(); repeat (3) tick();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rdy_i = ($urandom_range(0, 9) != 0);
      clear_i = ($urandom_range(0, 49) == 0);
      disp_valid_i = ($urandom_range(0, 9) < 6);
      disp_op_i = OP_W'($urandom); disp_rd_rename_i = ROB_W'($urandom);
      disp_pc_i = $urandom; disp_imm_i = $urandom;
      disp_vj_i = $urandom; disp_vk_i = $urandom;
      disp_qj_i = ROB_W'($urandom_range(0, 3)); disp_qk_i = ROB_W'($urandom_range(0, 3));
      disp_qj_busy_i = $urandom_range(0, 1) == 1; disp_qk_busy_i = $urandom_range(0, 1) == 1;
      alu_bc_valid_i = $urandom_range(0, 1) == 1;
      alu_bc_rename_i = ROB_W'($urandom_range(0, 3)); alu_bc_result_i = $urandom;
      tick();
    end
    idle(); repeat (3) tick();
    clear_i = 1'b1; tick();
    idle(); repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
